// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, registered 4-bit push/pop status and sticky overflow/underflow.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Clk_En,
  input  logic                    Fifo_Push_Flush,
  input  logic                    Fifo_Pop_Flush,
  input  logic                    PUSH,
  input  logic [DATA_WIDTH-1:0]   DIN,
  input  logic                    POP,
  output logic [DATA_WIDTH-1:0]   DOUT,
  output logic                    Dout_Valid,
  output logic [$clog2(DEPTH):0]  Level,
  output logic [3:0]              PUSH_FLAG,
  output logic [3:0]              POP_FLAG,
  output logic                    Almost_Full,
  output logic                    Almost_Empty,
  output logic                    Overflow,
  output logic                    Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_QTR   = LW'(DEPTH / 4);
  localparam logic [LW-1:0] C_HALF  = LW'(DEPTH / 2);
  localparam logic [LW-1:0] C_AF    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] C_AE    = LW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;

  logic                  w_flush;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_acc;
  logic                  w_push_acc;
  logic [AW-1:0]         w_rd_ptr_nxt;
  logic [LW-1:0]         w_level_nxt;
  logic [DATA_WIDTH-1:0] w_dout_nxt;
  logic                  w_dv_nxt;

  function automatic logic [3:0] push_flag_of(input logic [LW-1:0] lvl);
    logic [LW-1:0] free;
    free = C_DEPTH - lvl;
    if (lvl == '0)              return 4'd8;
    else if (free == '0)        return 4'd0;
    else if (free == LW'(1))    return 4'd1;
    else if (free < C_QTR)      return 4'd2;
    else if (free < C_HALF)     return 4'd3;
    else                        return 4'd4;
  endfunction

  function automatic logic [3:0] pop_flag_of(input logic [LW-1:0] lvl);
    if (lvl == '0)              return 4'd0;
    else if (lvl == C_DEPTH)    return 4'd8;
    else if (lvl == LW'(1))     return 4'd1;
    else if (lvl < C_QTR)       return 4'd2;
    else if (lvl < C_HALF)      return 4'd3;
    else                        return 4'd4;
  endfunction

  assign w_flush      = Fifo_Push_Flush | Fifo_Pop_Flush;
  assign w_empty      = (Level == '0);
  assign w_full       = (Level == C_DEPTH);
  assign w_pop_acc    = POP & ((FWFT != 0) ? Dout_Valid : !w_empty);
  assign w_push_acc   = PUSH & (!w_full | w_pop_acc);
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);
  assign w_level_nxt  = Level + LW'(w_push_acc) - LW'(w_pop_acc);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_dout_nxt = DOUT;
    w_dv_nxt   = Dout_Valid;
    if (FWFT == 0) begin
      if (w_pop_acc) w_dout_nxt = r_mem[r_rd_ptr];
      w_dv_nxt = w_pop_acc;
    end else begin
      w_dv_nxt = (w_level_nxt != '0);
      // The new head may be the word being written this very edge, so bypass DIN.
      if (w_pop_acc) begin
        if (w_push_acc && (w_rd_ptr_nxt == r_wr_ptr)) w_dout_nxt = DIN;
        else if (w_level_nxt != '0)                  w_dout_nxt = r_mem[w_rd_ptr_nxt];
      end else if (w_empty && w_push_acc) begin
        w_dout_nxt = DIN;
      end
    end
  end

  // NOTE: storage has no reset so it maps onto RAM; stale contents are unreachable once pointers clear.
  always_ff @(posedge Clk) begin
    if (Clk_En && !w_flush && w_push_acc) r_mem[r_wr_ptr] <= DIN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      Level        <= '0;
      DOUT         <= '0;
      Dout_Valid   <= 1'b0;
      PUSH_FLAG    <= 4'd8;
      POP_FLAG     <= 4'd0;
      Almost_Full  <= 1'b0;
      Almost_Empty <= 1'b1;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
    end else if (Clk_En) begin
      if (w_flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        Level        <= '0;
        DOUT         <= '0;
        Dout_Valid   <= 1'b0;
        PUSH_FLAG    <= 4'd8;
        POP_FLAG     <= 4'd0;
        Almost_Full  <= 1'b0;
        Almost_Empty <= 1'b1;
        Overflow     <= 1'b0;
        Underflow    <= 1'b0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop_acc)  r_rd_ptr <= w_rd_ptr_nxt;
        Level        <= w_level_nxt;
        DOUT         <= w_dout_nxt;
        Dout_Valid   <= w_dv_nxt;
        PUSH_FLAG    <= push_flag_of(w_level_nxt);
        POP_FLAG     <= pop_flag_of(w_level_nxt);
        Almost_Full  <= (w_level_nxt >= C_AF);
        Almost_Empty <= (w_level_nxt <= C_AE);
        if (PUSH && !w_push_acc) Overflow  <= 1'b1;
        if (POP && !w_pop_acc)   Underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-read and an FWFT instance (DEPTH=16, W=8)
// share one stimulus stream and are checked against hand-computed values.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pflush;
  logic       qflush;
  logic       push;
  logic       pop;
  logic [7:0] din;

  logic [7:0] a_dout, b_dout;
  logic       a_dv, b_dv;
  logic [4:0] a_level, b_level;
  logic [3:0] a_pf, a_qf, b_pf, b_qf;
  logic       a_af, a_ae, a_ovf, a_udf;
  logic       b_af, b_ae, b_ovf, b_udf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
    .Clk(clk), .Rst_n(rst_n), .Clk_En(en), .Fifo_Push_Flush(pflush), .Fifo_Pop_Flush(qflush),
    .PUSH(push), .DIN(din), .POP(pop), .DOUT(a_dout), .Dout_Valid(a_dv), .Level(a_level),
    .PUSH_FLAG(a_pf), .POP_FLAG(a_qf), .Almost_Full(a_af), .Almost_Empty(a_ae),
    .Overflow(a_ovf), .Underflow(a_udf)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .Clk(clk), .Rst_n(rst_n), .Clk_En(en), .Fifo_Push_Flush(pflush), .Fifo_Pop_Flush(qflush),
    .PUSH(push), .DIN(din), .POP(pop), .DOUT(b_dout), .Dout_Valid(b_dv), .Level(b_level),
    .PUSH_FLAG(b_pf), .POP_FLAG(b_qf), .Almost_Full(b_af), .Almost_Empty(b_ae),
    .Overflow(b_ovf), .Underflow(b_udf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lvl;
    rst_n = 1'b0; en = 1'b1; pflush = 1'b0; qflush = 1'b0;
    push = 1'b0; pop = 1'b0; din = '0;
    tick(); tick();

    check("rst_level", a_level, 0);
    check("rst_push_flag", a_pf, 8);
    check("rst_pop_flag", a_qf, 0);
    check("rst_ae", a_ae, 1);
    check("rst_af", a_af, 0);
    check("rst_dout", a_dout, 0);
    check("rst_dv", a_dv, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_udf", a_udf, 0);
    check("rst_fwft_dv", b_dv, 0);
    #2 rst_n = 1'b1;

    // Fill to full, then one push too many
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i);
      tick();
      check("fill_level", a_level, i + 1);
      check("fill_af", a_af, (i + 1) >= 12);
      check("fill_fwft_head", b_dout, 0);
    end
    check("full_pop_flag", a_qf, 8);
    check("full_push_flag", a_pf, 0);
    check("full_fwft_level", b_level, 16);
    din = 8'hFF;
    tick();
    check("ovf_set", a_ovf, 1);
    check("ovf_fwft_set", b_ovf, 1);
    check("ovf_level", a_level, 16);

    // Drain in order, checking flags at selected levels
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      lvl = 15 - i;
      check("drain_data", a_dout, i);
      check("drain_dv", a_dv, 1);
      check("drain_fwft_data", b_dout, (i < 15) ? i + 1 : 15);
      check("drain_fwft_dv", b_dv, i < 15);
      check("drain_level", a_level, lvl);
      check("drain_ae", a_ae, lvl <= 4);
      case (lvl)
        15: begin check("pf15", a_pf, 1); check("qf15", a_qf, 4); end
        13: begin check("pf13", a_pf, 2); check("qf13", a_qf, 4); end
        10: begin check("pf10", a_pf, 3); check("qf10", a_qf, 4); end
        5:  begin check("pf5",  a_pf, 4); check("qf5",  a_qf, 3); end
        3:  begin check("pf3",  a_pf, 4); check("qf3",  a_qf, 2); end
        1:  begin check("pf1",  a_pf, 4); check("qf1",  a_qf, 1); end
        0:  begin check("pf0",  a_pf, 8); check("qf0",  a_qf, 0); end
        default: ;
      endcase
    end
    tick();
    check("udf_set", a_udf, 1);
    check("udf_fwft_set", b_udf, 1);
    check("udf_dv", a_dv, 0);
    check("udf_level", a_level, 0);

    // Pointer wrap at constant level 8
    pop = 1'b0; qflush = 1'b1;
    tick();
    qflush = 1'b0;
    check("popflush_udf", a_udf, 0);
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h10 + i);
      tick();
    end
    pop = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 8'(8'h18 + k);
      tick();
      check("wrap_data", a_dout, 8'h10 + k);
      check("wrap_fwft_data", b_dout, 8'h11 + k);
      check("wrap_level", a_level, 8);
    end

    // FWFT bypass into empty, then push+pop at level 1
    push = 1'b0; pop = 1'b0; pflush = 1'b1;
    tick();
    pflush = 1'b0;
    check("flush_level", b_level, 0);
    check("flush_fwft_dv", b_dv, 0);
    push = 1'b1; din = 8'hA5;
    tick();
    push = 1'b0;
    tick();
    check("bypass_dout", b_dout, 8'hA5);
    check("bypass_dv", b_dv, 1);
    check("bypass_std_dv", a_dv, 0);
    push = 1'b1; pop = 1'b1; din = 8'h3C;
    tick();
    check("l1_pp_fwft_dout", b_dout, 8'h3C);
    check("l1_pp_fwft_dv", b_dv, 1);
    check("l1_pp_fwft_level", b_level, 1);
    check("l1_pp_std_dout", a_dout, 8'hA5);
    check("l1_pp_std_level", a_level, 1);

    // Push+pop while full
    push = 1'b0; pop = 1'b0; pflush = 1'b1;
    tick();
    pflush = 1'b0; push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(8'h40 + i);
      tick();
    end
    pop = 1'b1; din = 8'h99;
    tick();
    check("full_pp_level", a_level, 16);
    check("full_pp_ovf", a_ovf, 0);
    check("full_pp_std_dout", a_dout, 8'h40);
    check("full_pp_fwft_dout", b_dout, 8'h41);

    // Push+pop while empty
    push = 1'b0; pop = 1'b0; qflush = 1'b1;
    tick();
    qflush = 1'b0; push = 1'b1; pop = 1'b1; din = 8'h77;
    tick();
    check("empty_pp_level", a_level, 1);
    check("empty_pp_udf", a_udf, 1);
    check("empty_pp_std_dv", a_dv, 0);
    check("empty_pp_fwft_dout", b_dout, 8'h77);
    check("empty_pp_fwft_dv", b_dv, 1);
    check("empty_pp_fwft_udf", b_udf, 1);

    // Flush with PUSH high at level 5 and Overflow set
    push = 1'b0; pop = 1'b0; qflush = 1'b1;
    tick();
    qflush = 1'b0; push = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din = 8'(8'h50 + i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    repeat (11) tick();
    pop = 1'b0;
    check("pre_flush_level", a_level, 5);
    check("pre_flush_ovf", a_ovf, 1);
    push = 1'b1; din = 8'hEE; pflush = 1'b1;
    tick();
    push = 1'b0; pflush = 1'b0;
    check("flush_level5", a_level, 0);
    check("flush_ovf", a_ovf, 0);
    check("flush_push_flag", a_pf, 8);
    check("flush_dout", a_dout, 0);
    check("flush_fwft_dv2", b_dv, 0);

    // Clock-enable freeze
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h60 + i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    tick();
    en = 1'b0; push = 1'b1; pop = 1'b1; pflush = 1'b1; din = 8'h00;
    repeat (3) tick();
    check("frz_level", a_level, 2);
    check("frz_dout", a_dout, 8'h60);
    check("frz_dv", a_dv, 1);
    check("frz_fwft_dout", b_dout, 8'h61);
    check("frz_pop_flag", a_qf, 2);
    en = 1'b1; push = 1'b0; pop = 1'b0; pflush = 1'b0;
    tick();
    check("unfrz_dv", a_dv, 0);
    check("unfrz_level", a_level, 2);

    // Asynchronous reset mid-burst
    push = 1'b1; din = 8'h70;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_level", a_level, 0);
    check("arst_dout", a_dout, 0);
    check("arst_push_flag", a_pf, 8);
    check("arst_pop_flag", a_qf, 0);
    check("arst_ae", a_ae, 1);
    check("arst_fwft_dv", b_dv, 0);
    tick();
    push = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_level", a_level, 0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("post_rst_udf", a_udf, 1);
    check("post_rst_level2", a_level, 0);
    check("post_rst_dv", a_dv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
